// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the PC sequencer, the redirect/hazard logic and instruction memory.
// The master side drives control inputs and imem_ready; the slave side is pc_sequencer.
interface pc_sequencer_if;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        trap;
   logic        halt_req;
   logic        imem_ready;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        instr_valid;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        misalign;
   logic        halted;

   modport master (
      output stall, redirect_valid, redirect_target, trap, halt_req, imem_ready,
      input  imem_req, imem_addr, instr_valid, pc_out, pc_plus4, misalign, halted
   );

   modport slave (
      input  stall, redirect_valid, redirect_target, trap, halt_req, imem_ready,
      output imem_req, imem_addr, instr_valid, pc_out, pc_plus4, misalign, halted
   );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: owns fetch_pc, picks the next PC and runs the imem handshake.
//
// state    | meaning
// ST_RESET | held in reset / first cycle after release, no request yet
// ST_FETCH | requesting imem_addr, last request accepted
// ST_WAIT  | requesting imem_addr, memory not ready
// ST_HALT  | fetch stopped, only rst leaves
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input logic           clk,
   input logic           rst,
   pc_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_FETCH = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic        imem_req_q, imem_req_d;
   logic        instr_valid_q, instr_valid_d;
   logic        misalign_q, misalign_d;
   logic        halted_q, halted_d;

   logic        handshake;
   logic        target_misaligned;
   logic        flush;
   logic [31:0] seq_pc;

   always_comb begin
      seq_pc            = fetch_pc_q + 32'd4;
      target_misaligned = (bus.redirect_target[1:0] != 2'b00);
      flush             = bus.trap | bus.redirect_valid;
      // imem_req_q already reflects the previous stall; the current stall also blocks acceptance
      handshake         = imem_req_q & bus.imem_ready & ~bus.stall;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_RESET;
         fetch_pc_q    <= RESET_VECTOR;
         pc_out_q      <= 32'h0000_0000;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
         misalign_q    <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         pc_out_q      <= pc_out_d;
         imem_req_q    <= imem_req_d;
         instr_valid_q <= instr_valid_d;
         misalign_q    <= misalign_d;
         halted_q      <= halted_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET: state_d = ST_FETCH;
         ST_FETCH, ST_WAIT: begin
            if (flush) begin
               state_d = ST_FETCH;
            end else if (bus.halt_req) begin
               state_d = ST_HALT;
            end else if (!bus.stall && imem_req_q) begin
               state_d = bus.imem_ready ? ST_FETCH : ST_WAIT;
            end
         end
         ST_HALT:  state_d = ST_HALT;
         default:  state_d = ST_RESET;
      endcase
   end

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      pc_out_d      = pc_out_q;
      imem_req_d    = 1'b0;
      instr_valid_d = 1'b0;
      misalign_d    = 1'b0;
      halted_d      = 1'b0;
      if (state_q == ST_HALT) begin
         halted_d = 1'b1;
      end else if (bus.trap) begin
         fetch_pc_d = TRAP_VECTOR;
         imem_req_d = ~bus.stall;
      end else if (bus.redirect_valid) begin
         fetch_pc_d = target_misaligned ? TRAP_VECTOR : bus.redirect_target;
         misalign_d = target_misaligned;
         imem_req_d = ~bus.stall;
      end else if (bus.halt_req && state_q != ST_RESET) begin
         halted_d = 1'b1;
      end else if (bus.stall) begin
         instr_valid_d = instr_valid_q;
      end else begin
         imem_req_d = 1'b1;
         if (handshake) begin
            pc_out_d      = fetch_pc_q;
            instr_valid_d = 1'b1;
            fetch_pc_d    = seq_pc;
         end
      end
   end

   always_comb begin
      bus.imem_req    = imem_req_q;
      bus.imem_addr   = fetch_pc_q;
      bus.instr_valid = instr_valid_q;
      bus.pc_out      = pc_out_q;
      bus.pc_plus4    = seq_pc;
      bus.misalign    = misalign_q;
      bus.halted      = halted_q;
   end

endmodule
